// File: rtl/ep4_cmd_deframer.sv
// ep4_cmd_deframer
// Splits the raw EP4 host-to-device byte stream into command frames:
//   byte 0 = cmd_id, byte 1 = length[15:8], byte 2 = length[7:0], then payload.
// The header is presented on ep4_cmd_id / ep4_cmd_length with ep4_ready, and the
// payload is buffered in a first-word-fall-through FIFO popped by ep4_read.
//
// Build option: define CMD_TIMEOUT_EN to abort a command whose payload side
// stalls for TIMEOUT_CYCLES clocks (flags err_timeout). Without it err_timeout
// is tied low and a stalled command waits indefinitely.
module ep4_cmd_deframer #(
  parameter int FIFO_AW        = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        reset,
  // raw EP4 stream
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  // command controller port
  output logic        ep4_clk,
  output logic [7:0]  ep4_cmd_id,
  output logic [15:0] ep4_cmd_length,
  output logic        ep4_ready,
  input  logic        ep4_read,
  output logic [7:0]  ep4_data,
  output logic        ep4_avail,
  // error flags
  output logic        err_underrun,
  output logic        err_timeout,
  input  logic        err_clear
);

  localparam int              LP_DEPTH      = 1 << FIFO_AW;
  localparam logic [15:0]     LP_STALL_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_HDR_ID  = 3'd0,
    S_LEN_HI  = 3'd1,
    S_LEN_LO  = 3'd2,
    S_PAYLOAD = 3'd3,
    S_CONSUME = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // State and storage
  // ---------------------------------------------------------------------------
  state_t             r_state;
  logic [7:0]         r_cmd_id;
  logic [15:0]        r_cmd_length;
  logic               r_ready;
  logic [15:0]        r_in_remaining;   // payload bytes still to accept
  logic [15:0]        r_rd_remaining;   // payload bytes still to be popped
  logic               r_err_underrun;

  logic [7:0]         r_mem [LP_DEPTH];
  logic [FIFO_AW:0]   r_wr_ptr;
  logic [FIFO_AW:0]   r_rd_ptr;

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  logic               w_empty;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic               w_in_ready;
  logic               w_in_xfer;
  logic               w_ack_zero;
  logic               w_underrun;
  logic               w_done;
  logic               w_abort;
  logic [15:0]        w_len_full;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                      (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);

  // Consumer side is only live while a header is being presented.
  assign w_pop      = ep4_read && r_ready && !w_empty;
  assign w_ack_zero = ep4_read && r_ready && (r_rd_remaining == 16'd0);
  assign w_underrun = ep4_read && r_ready && w_empty && (r_rd_remaining != 16'd0);
  assign w_done     = (w_pop && (r_rd_remaining == 16'd1)) || w_ack_zero;

  assign w_len_full = {r_cmd_length[15:8], in_data};

  // Ready toward the stream: header states always accept; payload accepts while
  // there is room, or when a same-cycle pop frees a slot (full FIFO pass-through).
  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    w_in_ready = 1'b0;
    if (!reset) begin
      unique case (r_state)
        S_HDR_ID,
        S_LEN_HI,
        S_LEN_LO:  w_in_ready = 1'b1;
        S_PAYLOAD: w_in_ready = !w_full || w_pop;
        S_CONSUME: w_in_ready = 1'b0;
        default:   w_in_ready = 1'b0;
      endcase
    end
  end

  assign w_in_xfer = in_valid && w_in_ready;
  assign w_push    = w_in_xfer && (r_state == S_PAYLOAD);

  // ---------------------------------------------------------------------------
  // Optional payload stall watchdog
  // ---------------------------------------------------------------------------
`ifdef CMD_TIMEOUT_EN
  logic [15:0] r_stall;
  logic        r_err_timeout;
  logic        w_stall_phase;
  logic        w_activity;

  assign w_stall_phase = (r_state == S_PAYLOAD) || (r_state == S_CONSUME);
  assign w_activity    = w_in_xfer || w_pop || w_ack_zero;
  assign w_abort       = w_stall_phase && !w_activity && (r_stall == LP_STALL_LAST);

  // Idle-cycle counter: restarts on any traffic, counts only while a command is open.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall <= 16'd0;
    end else if (!w_stall_phase || w_activity || w_abort) begin
      r_stall <= 16'd0;
    end else begin
      r_stall <= r_stall + 16'd1;
    end
  end

  // Sticky timeout flag; a new timeout in the same cycle wins over err_clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_timeout <= 1'b0;
    end else if (w_abort) begin
      r_err_timeout <= 1'b1;
    end else if (err_clear) begin
      r_err_timeout <= 1'b0;
    end
  end

  assign err_timeout = r_err_timeout;
`else
  logic w_unused_timeout;

  assign w_unused_timeout = ^LP_STALL_LAST;
  assign w_abort          = 1'b0;
  assign err_timeout      = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Frame FSM with registered header outputs
  // ---------------------------------------------------------------------------
  // Header parse, payload accounting and end-of-command handshake.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values; a later assignment in the block wins.
    if (reset) begin
      r_state        <= S_HDR_ID;
      r_cmd_id       <= 8'h00;
      r_cmd_length   <= 16'h0000;
      r_ready        <= 1'b0;
      r_in_remaining <= 16'd0;
      r_rd_remaining <= 16'd0;
    end else if (w_abort) begin
      r_state        <= S_HDR_ID;
      r_ready        <= 1'b0;
      r_in_remaining <= 16'd0;
      r_rd_remaining <= 16'd0;
    end else begin
      unique case (r_state)
        S_HDR_ID: begin
          if (w_in_xfer) begin
            r_cmd_id <= in_data;
            r_state  <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (w_in_xfer) begin
            r_cmd_length[15:8] <= in_data;
            r_state            <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (w_in_xfer) begin
            r_cmd_length[7:0] <= in_data;
            r_in_remaining    <= w_len_full;
            r_rd_remaining    <= w_len_full;
            r_ready           <= 1'b1;
            r_state           <= (w_len_full != 16'd0) ? S_PAYLOAD : S_CONSUME;
          end
        end
        S_PAYLOAD: begin
          if (w_in_xfer) begin
            r_in_remaining <= r_in_remaining - 16'd1;
            if (r_in_remaining == 16'd1) begin
              r_state <= S_CONSUME;
            end
          end
        end
        S_CONSUME: begin
          // Waiting for the consumer; exit is handled by w_done below.
        end
        default: r_state <= S_HDR_ID;
      endcase

      if (w_pop) begin
        r_rd_remaining <= r_rd_remaining - 16'd1;
      end

      // Final pop or zero-length acknowledge closes the command.
      if (w_done) begin
        r_ready <= 1'b0;
        r_state <= S_HDR_ID;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Payload FIFO
  // ---------------------------------------------------------------------------
  // Read/write pointers; a timeout abort flushes by snapping read to write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (w_abort) begin
      r_rd_ptr <= r_wr_ptr;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Payload storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; validity is carried by the pointers
    // and the read port masks it while empty.
    if (w_push) begin
      r_mem[r_wr_ptr[FIFO_AW-1:0]] <= in_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky underrun flag
  // ---------------------------------------------------------------------------
  // A same-cycle underrun wins over err_clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_underrun <= 1'b0;
    end else if (w_underrun) begin
      r_err_underrun <= 1'b1;
    end else if (err_clear) begin
      r_err_underrun <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_ready       = w_in_ready;
  assign ep4_clk        = clk;
  assign ep4_cmd_id     = r_cmd_id;
  assign ep4_cmd_length = r_cmd_length;
  assign ep4_ready      = r_ready;
  assign ep4_avail      = !w_empty;
  assign ep4_data       = w_empty ? 8'h00 : r_mem[r_rd_ptr[FIFO_AW-1:0]];
  assign err_underrun   = r_err_underrun;

endmodule

// File: tb/tb_ep4_cmd_deframer.sv
// Self-checking bench for ep4_cmd_deframer: directed frames followed by a
// randomized stream compared against a queue-based frame model.
module tb_ep4_cmd_deframer;

  localparam int FIFO_AW = 4;
  localparam int DEPTH   = 16;
  localparam int TMO     = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        ep4_clk;
  logic [7:0]  ep4_cmd_id;
  logic [15:0] ep4_cmd_length;
  logic        ep4_ready;
  logic        ep4_read;
  logic [7:0]  ep4_data;
  logic        ep4_avail;
  logic        err_underrun;
  logic        err_timeout;
  logic        err_clear;

  int n_checks = 0;
  int n_fail   = 0;

  ep4_cmd_deframer #(
    .FIFO_AW        (FIFO_AW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .ep4_clk        (ep4_clk),
    .ep4_cmd_id     (ep4_cmd_id),
    .ep4_cmd_length (ep4_cmd_length),
    .ep4_ready      (ep4_ready),
    .ep4_read       (ep4_read),
    .ep4_data       (ep4_data),
    .ep4_avail      (ep4_avail),
    .err_underrun   (err_underrun),
    .err_timeout    (err_timeout),
    .err_clear      (err_clear)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one byte and hold it until accepted (bounded wait).
  task automatic send(input logic [7:0] b);
    int waited;
    waited   = 0;
    in_data  = b;
    in_valid = 1'b1;
    #1;
    while (!in_ready && waited < 200) begin
      tick();
      waited++;
      #1;
    end
    check("send_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  // Check the FIFO head, then pop it with a one-cycle ep4_read pulse.
  task automatic pop(input logic [7:0] exp, input string tag);
    check({tag, "_avail"}, ep4_avail, 1);
    check({tag, "_data"}, ep4_data, exp);
    ep4_read = 1'b1;
    tick();
    ep4_read = 1'b0;
  endtask

  // Random-phase model state
  logic [7:0]  q_stream [$];
  logic [7:0]  q_fifo   [$];
  logic [7:0]  b40      [40];
  logic [7:0]  m_id;
  logic [15:0] m_len;
  int          hdr_cnt;
  bit          m_active;
  bit          m_underrun;
  int          to_send;
  int          to_read;

  initial begin
    logic [7:0]  rid;
    logic [7:0]  rb;
    int          len;
    int          cnt;
    bit          exp_pop;
    bit          exp_in_ready;
    bit          ack0;
    bit          urun;
    bit          xfer;

    reset     = 1'b1;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    ep4_read  = 1'b0;
    err_clear = 1'b0;

    // ---- Reset state -------------------------------------------------------
    tick();
    tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_ep4_ready", ep4_ready, 0);
    check("rst_avail", ep4_avail, 0);
    check("rst_data", ep4_data, 0);
    check("rst_cmd_id", ep4_cmd_id, 0);
    check("rst_len", ep4_cmd_length, 0);
    check("rst_underrun", err_underrun, 0);
    check("rst_timeout", err_timeout, 0);
    check("ep4_clk", ep4_clk, clk);
    reset = 1'b0;
    tick();
    check("idle_in_ready", in_ready, 1);

    // ---- Basic 3-byte command ---------------------------------------------
    send(8'h12);
    send(8'h00);
    check("t1_ready_pre", ep4_ready, 0);
    send(8'h03);
    check("t1_ready", ep4_ready, 1);
    check("t1_id", ep4_cmd_id, 8'h12);
    check("t1_len", ep4_cmd_length, 16'd3);
    check("t1_avail_pre", ep4_avail, 0);
    send(8'hA1);
    check("t1_avail_first", ep4_avail, 1);
    send(8'hB2);
    send(8'hC3);
    check("t1_consume_in_ready", in_ready, 0);
    pop(8'hA1, "t1_p0");
    pop(8'hB2, "t1_p1");
    check("t1_ready_mid", ep4_ready, 1);
    pop(8'hC3, "t1_p2");
    check("t1_ready_end", ep4_ready, 0);
    check("t1_avail_end", ep4_avail, 0);
    check("t1_id_hold", ep4_cmd_id, 8'h12);
    check("t1_len_hold", ep4_cmd_length, 16'd3);
    check("t1_in_ready_end", in_ready, 1);

    // ---- Zero-length command ----------------------------------------------
    send(8'h05);
    send(8'h00);
    send(8'h00);
    check("t2_ready", ep4_ready, 1);
    check("t2_avail", ep4_avail, 0);
    check("t2_len", ep4_cmd_length, 0);
    tick();
    tick();
    check("t2_ready_hold", ep4_ready, 1);
    ep4_read = 1'b1;
    tick();
    ep4_read = 1'b0;
    check("t2_ready_end", ep4_ready, 0);
    check("t2_underrun", err_underrun, 0);
    check("t2_id_hold", ep4_cmd_id, 8'h05);
    ep4_read = 1'b1;
    tick();
    ep4_read = 1'b0;
    check("t2_idle_read", err_underrun, 0);

    // ---- Length 40 through a 16-deep FIFO ---------------------------------
    for (int i = 0; i < 40; i++) b40[i] = 8'($urandom);
    rid = 8'($urandom);
    send(rid);
    send(8'h00);
    send(8'd40);
    for (int i = 0; i < DEPTH; i++) send(b40[i]);
    in_data  = b40[DEPTH];
    in_valid = 1'b1;
    #1;
    check("t3_full_in_ready", in_ready, 0);
    for (int i = 0; i < 24; i++) begin
      in_data  = b40[DEPTH + i];
      in_valid = 1'b1;
      ep4_read = 1'b1;
      #1;
      check("t3_pass_in_ready", in_ready, 1);
      check("t3_pass_data", ep4_data, b40[i]);
      tick();
    end
    in_valid = 1'b0;
    ep4_read = 1'b0;
    #1;
    check("t3_still_full", in_ready, 0);
    for (int i = 24; i < 40; i++) pop(b40[i], "t3_drain");
    check("t3_ready_end", ep4_ready, 0);
    check("t3_id", ep4_cmd_id, rid);

    // ---- Underrun and clear priority --------------------------------------
    send(8'h33);
    send(8'h00);
    send(8'h02);
    send(8'h5A);
    pop(8'h5A, "t4_p0");
    check("t4_no_underrun", err_underrun, 0);
    ep4_read = 1'b1;
    tick();
    ep4_read = 1'b0;
    check("t4_underrun", err_underrun, 1);
    ep4_read  = 1'b1;
    err_clear = 1'b1;
    tick();
    ep4_read  = 1'b0;
    err_clear = 1'b0;
    check("t4_set_beats_clear", err_underrun, 1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("t4_cleared", err_underrun, 0);
    send(8'h6B);
    pop(8'h6B, "t4_p1");
    check("t4_ready_end", ep4_ready, 0);

    // ---- Reset mid-payload ------------------------------------------------
    send(8'h44);
    send(8'h00);
    send(8'h0A);
    for (int i = 0; i < 5; i++) send(8'($urandom));
    check("t5_buffered", ep4_avail, 1);
    reset = 1'b1;
    #1;
    check("t5_in_ready", in_ready, 0);
    check("t5_ready", ep4_ready, 0);
    check("t5_avail", ep4_avail, 0);
    check("t5_data", ep4_data, 0);
    check("t5_id", ep4_cmd_id, 0);
    check("t5_len", ep4_cmd_length, 0);
    tick();
    reset = 1'b0;
    tick();
    send(8'h07);
    send(8'h00);
    send(8'h01);
    send(8'hEE);
    check("t5_new_id", ep4_cmd_id, 8'h07);
    check("t5_new_len", ep4_cmd_length, 16'd1);
    pop(8'hEE, "t5_p0");
    check("t5_ready_end", ep4_ready, 0);

    // ---- Payload stall ----------------------------------------------------
    send(8'h21);
    send(8'h00);
    send(8'h04);
    send(8'h99);
`ifdef CMD_TIMEOUT_EN
    cnt = 0;
    while (!err_timeout && cnt < 300) begin
      tick();
      cnt++;
    end
    check("t6_timeout_cycles", cnt, TMO);
    check("t6_timeout", err_timeout, 1);
    check("t6_ready", ep4_ready, 0);
    check("t6_avail", ep4_avail, 0);
    send(8'h22);
    send(8'h00);
    send(8'h00);
    check("t6_next_ready", ep4_ready, 1);
    check("t6_next_id", ep4_cmd_id, 8'h22);
    ep4_read = 1'b1;
    tick();
    ep4_read = 1'b0;
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("t6_timeout_clr", err_timeout, 0);
`else
    for (int i = 0; i < 150; i++) tick();
    check("t6_wait_ready", ep4_ready, 1);
    check("t6_wait_avail", ep4_avail, 1);
    check("t6_no_timeout", err_timeout, 0);
    send(8'h98);
    send(8'h97);
    send(8'h96);
    pop(8'h99, "t6_p0");
    pop(8'h98, "t6_p1");
    pop(8'h97, "t6_p2");
    pop(8'h96, "t6_p3");
`endif
    check("t6_ready_end", ep4_ready, 0);

    // ---- Randomized stream against the frame model ------------------------
    hdr_cnt    = 0;
    m_active   = 1'b0;
    m_underrun = 1'b0;
    m_id       = 8'h00;
    m_len      = 16'h0000;
    to_send    = 0;
    to_read    = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (q_stream.size() == 0) begin
        len = $urandom_range(0, 40);
        q_stream.push_back(8'($urandom));
        q_stream.push_back(8'(len >> 8));
        q_stream.push_back(8'(len));
        for (int k = 0; k < len; k++) q_stream.push_back(8'($urandom));
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = q_stream[0];
      ep4_read  = ($urandom_range(0, 9) < 6);
      err_clear = ($urandom_range(0, 29) == 0);
      #1;

      exp_pop      = ep4_read && m_active && (q_fifo.size() > 0);
      ack0         = ep4_read && m_active && (to_read == 0);
      urun         = ep4_read && m_active && (q_fifo.size() == 0) && (to_read != 0);
      exp_in_ready = !m_active ? 1'b1 :
                     (to_send > 0) ? ((q_fifo.size() < DEPTH) || exp_pop) : 1'b0;

      check("rnd_in_ready", in_ready, exp_in_ready);
      check("rnd_ready", ep4_ready, m_active);
      check("rnd_avail", ep4_avail, q_fifo.size() > 0);
      if (q_fifo.size() > 0) check("rnd_data", ep4_data, q_fifo[0]);
      check("rnd_underrun", err_underrun, m_underrun);
      check("rnd_timeout", err_timeout, 0);
      if (m_active) begin
        check("rnd_id", ep4_cmd_id, m_id);
        check("rnd_len", ep4_cmd_length, m_len);
      end

      xfer = in_valid && exp_in_ready;
      if (xfer) begin
        rb = q_stream.pop_front();
        if (!m_active) begin
          if (hdr_cnt == 0) begin
            m_id    = rb;
            hdr_cnt = 1;
          end else if (hdr_cnt == 1) begin
            m_len[15:8] = rb;
            hdr_cnt     = 2;
          end else begin
            m_len[7:0] = rb;
            hdr_cnt    = 0;
            m_active   = 1'b1;
            to_send    = int'(m_len);
            to_read    = int'(m_len);
          end
        end else begin
          q_fifo.push_back(rb);
          to_send--;
        end
      end
      if (exp_pop) begin
        void'(q_fifo.pop_front());
        to_read--;
        if (to_read == 0) m_active = 1'b0;
      end
      if (ack0) m_active = 1'b0;
      if (urun) m_underrun = 1'b1;
      else if (err_clear) m_underrun = 1'b0;

      tick();
    end
    in_valid  = 1'b0;
    ep4_read  = 1'b0;
    err_clear = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
